stage_memory_access: RTL and testbench

- Pipeline stage directly downstream of execute.
- Registers execute results and performs loads/stores over a valid/ready data-memory port, with byte-lane steering and load sign/zero extension.
- Maintains the LL/SC link bit and reports address-error exceptions.
- Feeds writeback, drives the memory-wait hazard signal back to the hazard unit, and provides the llbit value that execute consumes.

---
 rtl/stage_memory_access.sv | 211 +++++++++++++++++++++
 tb/tb_stage_memory_access.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory_access.sv
// Memory-access pipeline stage: registers execute results, runs loads/stores over a valid/ready
// data port with lane steering and load extension, and keeps the LL/SC link bit.
module stage_memory_access #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          bubble,
  input  logic          nullify,
  input  logic          llbit_clear,
  input  logic          in_valid,
  input  logic [3:0]    in_mem_op,
  input  logic [31:0]   in_mem_addr,
  input  logic [DW-1:0] in_store_data,
  input  logic [4:0]    in_dest_reg,
  input  logic [DW-1:0] in_dest_reg_data,
  input  logic          in_write_reg,
  input  logic [31:0]   in_pc,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wait_mem,
  output logic          out_valid,
  output logic          out_write_reg,
  output logic [4:0]    out_dest_reg,
  output logic [DW-1:0] out_dest_reg_data,
  output logic [31:0]   out_pc,
  output logic          llbit,
  output logic          exc_adel,
  output logic          exc_ades,
  output logic [31:0]   exc_badvaddr
);

  localparam logic [3:0] OpLb = 4'd1, OpLbu = 4'd2, OpLh = 4'd3, OpLhu = 4'd4, OpLw = 4'd5;
  localparam logic [3:0] OpSb = 4'd6, OpSh = 4'd7, OpSw = 4'd8, OpLl = 4'd9, OpSc = 4'd10;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDrain} state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLl});
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op inside {OpSb, OpSh, OpSw, OpSc});
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
    if (op inside {OpLh, OpLhu, OpSh}) return a[0];
    if (op inside {OpLw, OpLl, OpSw, OpSc}) return |a;
    return 1'b0;
  endfunction

  state_e        state_q, state_d;
  logic          valid_q, done_q, done_d, llbit_q, llbit_d, sc_success_q, write_reg_q;
  logic [3:0]    op_q;
  logic [31:0]   addr_q, pc_q;
  logic [DW-1:0] store_q, dest_data_q, load_data_q, load_data_d, load_fmt;
  logic [4:0]    dest_q;
  logic          is_load, is_store, misaligned, fault, kill, hold, capture, start, ll_set;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign is_load    = op_is_load(op_q);
  assign is_store   = op_is_store(op_q);
  assign misaligned = op_misaligned(op_q, addr_q[1:0]);
  assign fault      = valid_q & (is_load | is_store) & misaligned;
  assign wait_mem   = (valid_q & (is_load | is_store) & ~misaligned & ~done_q) |
                      (state_q == StDrain);
  assign kill       = nullify | bubble;
  assign hold       = stall | wait_mem;
  assign capture    = ~kill & ~hold;
  // A failed SC never starts a memory transaction.
  assign start      = capture & in_valid & (op_is_load(in_mem_op) | op_is_store(in_mem_op)) &
                      ~op_misaligned(in_mem_op, in_mem_addr[1:0]) &
                      ((in_mem_op != OpSc) | llbit_q);

  assign ld_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = dmem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_fmt = dmem_rdata;
    unique case (op_q)
      OpLb:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   load_fmt = {24'b0, ld_byte};
      OpLh:    load_fmt = {{16{ld_half[15]}}, ld_half};
      OpLhu:   load_fmt = {16'b0, ld_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    load_data_d = load_data_q;
    ll_set      = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StReq;
      StReq: begin
        if (kill) begin
          // An accepted load still owes a response that must be swallowed.
          state_d = (dmem_ready & is_load & ~dmem_rvalid) ? StDrain : StIdle;
        end else if (dmem_ready) begin
          if (is_store) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (dmem_rvalid) begin
            state_d     = StIdle;
            done_d      = 1'b1;
            load_data_d = load_fmt;
            ll_set      = (op_q == OpLl);
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (kill) begin
          state_d = dmem_rvalid ? StIdle : StDrain;
        end else if (dmem_rvalid) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          load_data_d = load_fmt;
          ll_set      = (op_q == OpLl);
        end
      end
      StDrain: if (dmem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (capture) done_d = in_valid & (in_mem_op == OpSc) & ~llbit_q;

    llbit_d = llbit_q;
    if (ll_set) llbit_d = 1'b1;
    if (capture & in_valid & (in_mem_op == OpSc)) llbit_d = 1'b0;
    if (llbit_clear) llbit_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      llbit_q      <= 1'b0;
      load_data_q  <= '0;
      sc_success_q <= 1'b0;
      write_reg_q  <= 1'b0;
      op_q         <= '0;
      addr_q       <= '0;
      pc_q         <= '0;
      store_q      <= '0;
      dest_data_q  <= '0;
      dest_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      llbit_q     <= llbit_d;
      load_data_q <= load_data_d;
      if (kill) begin
        valid_q <= 1'b0;
      end else if (!hold) begin
        valid_q      <= in_valid;
        op_q         <= in_mem_op;
        addr_q       <= in_mem_addr;
        store_q      <= in_store_data;
        dest_q       <= in_dest_reg;
        dest_data_q  <= in_dest_reg_data;
        write_reg_q  <= in_write_reg;
        pc_q         <= in_pc;
        sc_success_q <= llbit_q;
      end
    end
  end

  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = store_q;
    unique case (op_q)
      OpSb: begin
        dmem_be    = 4'b0001 << addr_q[1:0];
        dmem_wdata = {4{store_q[7:0]}};
      end
      OpSh: begin
        dmem_be    = 4'b0011 << addr_q[1:0];
        dmem_wdata = {2{store_q[15:0]}};
      end
      default: dmem_be = (is_load | is_store) ? 4'b1111 : 4'b0000;
    endcase
  end

  assign dmem_req  = (state_q == StReq);
  assign dmem_we   = is_store;
  assign dmem_addr = {addr_q[AW-1:2], 2'b00};

  assign out_valid         = valid_q & ~wait_mem;
  assign out_write_reg     = out_valid & write_reg_q & ~fault;
  assign out_dest_reg      = dest_q;
  assign out_pc            = pc_q;
  assign out_dest_reg_data = is_load ? load_data_q :
                             (op_q == OpSc) ? {{(DW-1){1'b0}}, sc_success_q} : dest_data_q;
  assign llbit             = llbit_q;
  assign exc_adel          = fault & is_load;
  assign exc_ades          = fault & is_store;
  assign exc_badvaddr      = addr_q;

endmodule

// File: tb/tb_stage_memory_access.sv
// Directed bench for stage_memory_access: lane steering, extension, faults, LL/SC, drain, reset.
module tb_stage_memory_access;

  logic        clk = 1'b0;
  logic        reset, stall, bubble, nullify, llbit_clear;
  logic        in_valid, in_write_reg;
  logic [3:0]  in_mem_op;
  logic [31:0] in_mem_addr, in_store_data, in_dest_reg_data, in_pc;
  logic [4:0]  in_dest_reg;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wait_mem, out_valid, out_write_reg, llbit, exc_adel, exc_ades;
  logic [4:0]  out_dest_reg;
  logic [31:0] out_dest_reg_data, out_pc, exc_badvaddr;

  int n_checks = 0;
  int n_errors = 0;
  int req_cycles;

  always #5 clk = ~clk;

  stage_memory_access #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .nullify(nullify),
    .llbit_clear(llbit_clear), .in_valid(in_valid), .in_mem_op(in_mem_op),
    .in_mem_addr(in_mem_addr), .in_store_data(in_store_data), .in_dest_reg(in_dest_reg),
    .in_dest_reg_data(in_dest_reg_data), .in_write_reg(in_write_reg), .in_pc(in_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wait_mem(wait_mem), .out_valid(out_valid),
    .out_write_reg(out_write_reg), .out_dest_reg(out_dest_reg),
    .out_dest_reg_data(out_dest_reg_data), .out_pc(out_pc), .llbit(llbit),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] dest, input logic [31:0] ddata, input logic wr,
                       input logic [31:0] pc);
    in_valid         = 1'b1;
    in_mem_op        = op;
    in_mem_addr      = addr;
    in_store_data    = sdata;
    in_dest_reg      = dest;
    in_dest_reg_data = ddata;
    in_write_reg     = wr;
    in_pc            = pc;
  endtask

  task automatic step();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; bubble = 1'b0; nullify = 1'b0; llbit_clear = 1'b0;
    in_valid = 1'b0; in_mem_op = '0; in_mem_addr = '0; in_store_data = '0;
    in_dest_reg = '0; in_dest_reg_data = '0; in_write_reg = 1'b0; in_pc = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_llbit", 32'(llbit), 32'd0);
    check_eq("rst_data", out_dest_reg_data, 32'h0);
    check_eq("rst_wait", 32'(wait_mem), 32'd0);
    reset = 1'b1;

    // Plain ALU result passes through
    drive(4'd0, 32'h0, 32'h0, 5'd7, 32'h1234_5678, 1'b1, 32'h400);
    step();
    check_eq("alu_valid", 32'(out_valid), 32'd1);
    check_eq("alu_data", out_dest_reg_data, 32'h1234_5678);
    check_eq("alu_wr", 32'(out_write_reg), 32'd1);
    check_eq("alu_pc", out_pc, 32'h400);

    // LB 0x103, ready and rvalid together
    drive(4'd1, 32'h103, 32'h0, 5'd3, 32'h0, 1'b1, 32'h404);
    step();
    check_eq("lb_req", 32'(dmem_req), 32'd1);
    check_eq("lb_addr", dmem_addr, 32'h100);
    check_eq("lb_be", 32'(dmem_be), 32'hF);
    check_eq("lb_we", 32'(dmem_we), 32'd0);
    check_eq("lb_wait", 32'(wait_mem), 32'd1);
    dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
    step();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    check_eq("lb_valid", 32'(out_valid), 32'd1);
    check_eq("lb_data", out_dest_reg_data, 32'hFFFF_FF80);
    check_eq("lb_dest", 32'(out_dest_reg), 32'd3);

    // LBU through the RESP state
    drive(4'd2, 32'h103, 32'h0, 5'd3, 32'h0, 1'b1, 32'h408);
    step();
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    check_eq("lbu_resp_req", 32'(dmem_req), 32'd0);
    check_eq("lbu_resp_wait", 32'(wait_mem), 32'd1);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    check_eq("lbu_data", out_dest_reg_data, 32'h0000_0080);
    check_eq("lbu_valid", 32'(out_valid), 32'd1);

    // SH 0x202 with ready delayed 3 cycles
    drive(4'd7, 32'h202, 32'h0000_BEEF, 5'd0, 32'h0, 1'b0, 32'h40C);
    req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (dmem_req) req_cycles++;
      check_eq("sh_wait", 32'(wait_mem), 32'd1);
      if (k == 0) begin
        check_eq("sh_be", 32'(dmem_be), 32'hC);
        check_eq("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check_eq("sh_we", 32'(dmem_we), 32'd1);
      end
      if (k == 3) dmem_ready = 1'b1;
    end
    step();
    dmem_ready = 1'b0;
    check_eq("sh_req_cycles", 32'(req_cycles), 32'd4);
    check_eq("sh_req_off", 32'(dmem_req), 32'd0);
    check_eq("sh_done_wait", 32'(wait_mem), 32'd0);

    // SB 0x301 lane
    drive(4'd6, 32'h301, 32'h0000_00AB, 5'd0, 32'h0, 1'b0, 32'h410);
    step();
    check_eq("sb_be", 32'(dmem_be), 32'h2);
    check_eq("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;

    // Misaligned LW and SW
    drive(4'd5, 32'h6, 32'h0, 5'd9, 32'h0, 1'b1, 32'h414);
    step();
    check_eq("lw_adel", 32'(exc_adel), 32'd1);
    check_eq("lw_ades", 32'(exc_ades), 32'd0);
    check_eq("lw_badv", exc_badvaddr, 32'h6);
    check_eq("lw_noreq", 32'(dmem_req), 32'd0);
    check_eq("lw_nowr", 32'(out_write_reg), 32'd0);
    check_eq("lw_nowait", 32'(wait_mem), 32'd0);
    drive(4'd8, 32'h102, 32'h0, 5'd0, 32'h0, 1'b0, 32'h418);
    step();
    check_eq("sw_ades", 32'(exc_ades), 32'd1);
    check_eq("sw_adel", 32'(exc_adel), 32'd0);
    check_eq("sw_badv", exc_badvaddr, 32'h102);

    // LL then SC success then SC failure
    drive(4'd9, 32'h40, 32'h0, 5'd2, 32'h0, 1'b1, 32'h41C);
    step();
    check_eq("ll_req", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_1234;
    step();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    check_eq("ll_llbit", 32'(llbit), 32'd1);
    check_eq("ll_data", out_dest_reg_data, 32'h0000_1234);
    drive(4'd10, 32'h40, 32'h5, 5'd4, 32'h0, 1'b1, 32'h420);
    step();
    check_eq("sc_req", 32'(dmem_req), 32'd1);
    check_eq("sc_be", 32'(dmem_be), 32'hF);
    check_eq("sc_wdata", dmem_wdata, 32'h5);
    check_eq("sc_llbit", 32'(llbit), 32'd0);
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    check_eq("sc_result", out_dest_reg_data, 32'd1);
    check_eq("sc_valid", 32'(out_valid), 32'd1);
    drive(4'd10, 32'h40, 32'h5, 5'd4, 32'h0, 1'b1, 32'h424);
    step();
    check_eq("sc2_noreq", 32'(dmem_req), 32'd0);
    check_eq("sc2_nowait", 32'(wait_mem), 32'd0);
    check_eq("sc2_result", out_dest_reg_data, 32'd0);
    check_eq("sc2_valid", 32'(out_valid), 32'd1);

    // llbit_clear coinciding with LL completion
    drive(4'd9, 32'h44, 32'h0, 5'd2, 32'h0, 1'b1, 32'h428);
    step();
    dmem_ready = 1'b1; dmem_rvalid = 1'b1; llbit_clear = 1'b1;
    step();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; llbit_clear = 1'b0;
    check_eq("llclr_llbit", 32'(llbit), 32'd0);

    // LW accepted, nullified in RESP, response drained
    drive(4'd5, 32'h80, 32'h0, 5'd5, 32'h0, 1'b1, 32'h42C);
    step();
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    check_eq("drain_resp_wait", 32'(wait_mem), 32'd1);
    nullify = 1'b1;
    step();
    nullify = 1'b0;
    check_eq("drain_wait0", 32'(wait_mem), 32'd1);
    check_eq("drain_valid0", 32'(out_valid), 32'd0);
    step();
    check_eq("drain_wait1", 32'(wait_mem), 32'd1);
    check_eq("drain_valid1", 32'(out_valid), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_rvalid = 1'b0;
    check_eq("drain_done_wait", 32'(wait_mem), 32'd0);
    check_eq("drain_done_valid", 32'(out_valid), 32'd0);
    check_eq("drain_done_req", 32'(dmem_req), 32'd0);

    // Reset in the middle of a request
    drive(4'd9, 32'h48, 32'h0, 5'd2, 32'h0, 1'b1, 32'h430);
    step();
    dmem_ready = 1'b1; dmem_rvalid = 1'b1;
    step();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    check_eq("rr_llbit_set", 32'(llbit), 32'd1);
    drive(4'd5, 32'h48, 32'h0, 5'd6, 32'h0, 1'b1, 32'h434);
    step();
    check_eq("rr_req", 32'(dmem_req), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("rr_noreq", 32'(dmem_req), 32'd0);
    check_eq("rr_llbit", 32'(llbit), 32'd0);
    check_eq("rr_valid", 32'(out_valid), 32'd0);
    check_eq("rr_wait", 32'(wait_mem), 32'd0);
    check_eq("rr_data", out_dest_reg_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
